// File: rtl/fetch_unit_pkg.sv
// Shared encodings and constants for the instruction fetch stage.
package fetch_unit_pkg;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] NOP = 16'h0800;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;
endpackage

// File: rtl/fetch_unit_cla16.sv
// 16-bit carry-lookahead adder: 4-bit lookahead groups with a lookahead carry across groups.
module fetch_unit_cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);
  logic [15:0] g, p, c;
  logic [2:0]  gg, gp;
  logic [3:0]  gc;

  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 3; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum = p ^ c;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues single reads, tracks squashed returns, and owns the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC,
  output logic [15:0] MemAddr,
  output logic        MemRd,
  input  logic [15:0] MemData,
  input  logic        MemDone,
  input  logic        Flush,
  input  logic        IdStall,
  input  logic        HaltIn,
  output logic        PcStall,
  output logic [15:0] Instr,
  output logic [15:0] PcNext,
  output logic        IfValid
);
  state_t      state;
  logic [15:0] fetch_addr_p0;
  logic        squash;
  logic [15:0] pc_plus2_p0;
  logic [15:0] instr_p1, pcnext_p1;
  logic        vld_p1;
  logic        flush_take, accept;

  fetch_unit_cla16 u_pc_add (
    .a   (fetch_addr_p0),
    .b   (16'd2),
    .cin (1'b0),
    .sum (pc_plus2_p0)
  );

  always_comb begin
    MemRd      = (state == S_IDLE);
    MemAddr    = (state == S_IDLE) ? PC : fetch_addr_p0;
    flush_take = Flush && !HaltIn && (state != S_HALTED);
    accept     = (state == S_WAIT) && MemDone && !Flush && !HaltIn && !squash;
    PcStall    = !(flush_take || accept);
  end

  // IF/ID register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      fetch_addr_p0 <= '0;
      squash        <= 1'b0;
      instr_p1      <= NOP;
      pcnext_p1     <= '0;
      vld_p1        <= 1'b0;
    end else if (HaltIn) begin
      state  <= S_HALTED;
      vld_p1 <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Flush) begin
            vld_p1   <= 1'b0;
            instr_p1 <= NOP;
          end else begin
            fetch_addr_p0 <= PC;
            state         <= S_WAIT;
            if (!IdStall) vld_p1 <= 1'b0;
          end
        end
        S_WAIT: begin
          if (Flush) begin
            vld_p1   <= 1'b0;
            instr_p1 <= NOP;
            // A flush coinciding with the return drops it outright; otherwise drop the later return.
            if (MemDone) begin
              state  <= S_IDLE;
              squash <= 1'b0;
            end else begin
              squash <= 1'b1;
            end
          end else if (MemDone) begin
            if (squash) begin
              squash <= 1'b0;
              state  <= S_IDLE;
              if (!IdStall) vld_p1 <= 1'b0;
            end else begin
              instr_p1  <= MemData;
              pcnext_p1 <= pc_plus2_p0;
              vld_p1    <= 1'b1;
              state     <= IdStall ? S_HOLD : S_IDLE;
            end
          end else if (!IdStall) begin
            vld_p1 <= 1'b0;
          end
        end
        S_HOLD: begin
          if (Flush) begin
            vld_p1   <= 1'b0;
            instr_p1 <= NOP;
            state    <= S_IDLE;
          end else if (!IdStall) begin
            vld_p1 <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign Instr   = instr_p1;
  assign PcNext  = pcnext_p1;
  assign IfValid = vld_p1;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] PC = '0, MemData = '0;
  logic        MemDone = 1'b0, Flush = 1'b0, IdStall = 1'b0, HaltIn = 1'b0;
  logic [15:0] MemAddr, Instr, PcNext;
  logic        MemRd, PcStall, IfValid;

  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .PC(PC), .MemAddr(MemAddr), .MemRd(MemRd),
    .MemData(MemData), .MemDone(MemDone), .Flush(Flush), .IdStall(IdStall),
    .HaltIn(HaltIn), .PcStall(PcStall), .Instr(Instr), .PcNext(PcNext), .IfValid(IfValid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; MemDone = 0; Flush = 0; IdStall = 0; HaltIn = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    PC = 16'h1234;
    @(negedge clk);
    checks++; if (MemRd !== 1'b1) begin errors++; $display("FAIL reset_memrd got=%b want=1", MemRd); end
    checks++; if (MemAddr !== 16'h1234) begin errors++; $display("FAIL reset_memaddr got=%h want=1234", MemAddr); end
    checks++; if (PcStall !== 1'b1) begin errors++; $display("FAIL reset_pcstall got=%b want=1", PcStall); end
    checks++; if (Instr !== 16'h0800) begin errors++; $display("FAIL reset_instr got=%h want=0800", Instr); end
    checks++; if (PcNext !== 16'h0000) begin errors++; $display("FAIL reset_pcnext got=%h want=0000", PcNext); end
    checks++; if (IfValid !== 1'b0) begin errors++; $display("FAIL reset_ifvalid got=%b want=0", IfValid); end
  endtask

  task automatic test_basic_fetch();
    int lows = 0;
    do_reset();
    PC = 16'h0000;
    for (int k = 0; k < 6; k++) begin
      MemDone = (k == 3);
      MemData = (k == 3) ? 16'h4000 : 16'hDEAD;
      @(negedge clk);
      if (!PcStall) lows++;
      if (k == 1) begin
        checks++; if (MemRd !== 1'b0) begin errors++; $display("FAIL basic_wait_memrd got=%b want=0", MemRd); end
        checks++; if (MemAddr !== 16'h0000) begin errors++; $display("FAIL basic_wait_addr got=%h want=0000", MemAddr); end
      end
      if (k == 4) begin
        checks++; if (Instr !== 16'h4000) begin errors++; $display("FAIL basic_instr got=%h want=4000", Instr); end
        checks++; if (PcNext !== 16'h0002) begin errors++; $display("FAIL basic_pcnext got=%h want=0002", PcNext); end
        checks++; if (IfValid !== 1'b1) begin errors++; $display("FAIL basic_ifvalid got=%b want=1", IfValid); end
        checks++; if (MemRd !== 1'b1) begin errors++; $display("FAIL basic_next_memrd got=%b want=1", MemRd); end
      end
      if (k == 5) begin
        checks++; if (IfValid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b want=0", IfValid); end
      end
      step();
    end
    MemDone = 0;
    checks++; if (lows != 1) begin errors++; $display("FAIL basic_stall_low_cycles got=%0d want=1", lows); end
  endtask

  task automatic test_hold();
    do_reset();
    PC = 16'h0100;
    step();
    MemDone = 1; MemData = 16'hABCD; IdStall = 1;
    @(negedge clk);
    checks++; if (PcStall !== 1'b0) begin errors++; $display("FAIL hold_accept_pcstall got=%b want=0", PcStall); end
    step();
    MemDone = 0;
    for (int k = 0; k < 4; k++) begin
      IdStall = (k < 3);
      @(negedge clk);
      checks++; if (Instr !== 16'hABCD) begin errors++; $display("FAIL hold_instr[%0d] got=%h want=abcd", k, Instr); end
      checks++; if (PcNext !== 16'h0102) begin errors++; $display("FAIL hold_pcnext[%0d] got=%h want=0102", k, PcNext); end
      checks++; if (IfValid !== 1'b1) begin errors++; $display("FAIL hold_ifvalid[%0d] got=%b want=1", k, IfValid); end
      checks++; if (PcStall !== 1'b1) begin errors++; $display("FAIL hold_pcstall[%0d] got=%b want=1", k, PcStall); end
      checks++; if (MemRd !== 1'b0) begin errors++; $display("FAIL hold_memrd[%0d] got=%b want=0", k, MemRd); end
      step();
    end
    PC = 16'h0102;
    @(negedge clk);
    checks++; if (MemRd !== 1'b1) begin errors++; $display("FAIL hold_exit_memrd got=%b want=1", MemRd); end
    checks++; if (MemAddr !== 16'h0102) begin errors++; $display("FAIL hold_exit_addr got=%h want=0102", MemAddr); end
    checks++; if (IfValid !== 1'b0) begin errors++; $display("FAIL hold_exit_ifvalid got=%b want=0", IfValid); end
  endtask

  task automatic test_flush_wait();
    do_reset();
    PC = 16'h0200;
    step();
    Flush = 1;
    @(negedge clk);
    checks++; if (PcStall !== 1'b0) begin errors++; $display("FAIL flushw_pcstall got=%b want=0", PcStall); end
    step();
    Flush = 0; PC = 16'h0300;
    @(negedge clk);
    checks++; if (MemRd !== 1'b0) begin errors++; $display("FAIL flushw_memrd got=%b want=0", MemRd); end
    step();
    MemDone = 1; MemData = 16'h1234;
    @(negedge clk);
    checks++; if (PcStall !== 1'b1) begin errors++; $display("FAIL flushw_drop_pcstall got=%b want=1", PcStall); end
    step();
    MemDone = 0;
    @(negedge clk);
    checks++; if (IfValid !== 1'b0) begin errors++; $display("FAIL flushw_ifvalid got=%b want=0", IfValid); end
    checks++; if (Instr !== 16'h0800) begin errors++; $display("FAIL flushw_instr got=%h want=0800", Instr); end
    checks++; if (MemRd !== 1'b1) begin errors++; $display("FAIL flushw_memrd_new got=%b want=1", MemRd); end
    checks++; if (MemAddr !== 16'h0300) begin errors++; $display("FAIL flushw_addr got=%h want=0300", MemAddr); end
  endtask

  task automatic test_flush_done();
    do_reset();
    PC = 16'h0400;
    step();
    Flush = 1; MemDone = 1; MemData = 16'h5555;
    @(negedge clk);
    checks++; if (PcStall !== 1'b0) begin errors++; $display("FAIL flushd_pcstall got=%b want=0", PcStall); end
    step();
    Flush = 0; MemDone = 0; PC = 16'h0500;
    @(negedge clk);
    checks++; if (IfValid !== 1'b0) begin errors++; $display("FAIL flushd_ifvalid got=%b want=0", IfValid); end
    checks++; if (MemAddr !== 16'h0500) begin errors++; $display("FAIL flushd_addr got=%h want=0500", MemAddr); end
    step();
    MemDone = 1; MemData = 16'h6666;
    @(negedge clk);
    checks++; if (PcStall !== 1'b0) begin errors++; $display("FAIL flushd_next_accept got=%b want=0", PcStall); end
    step();
    MemDone = 0;
    @(negedge clk);
    checks++; if (Instr !== 16'h6666) begin errors++; $display("FAIL flushd_instr got=%h want=6666", Instr); end
    checks++; if (IfValid !== 1'b1) begin errors++; $display("FAIL flushd_valid got=%b want=1", IfValid); end
    checks++; if (PcNext !== 16'h0502) begin errors++; $display("FAIL flushd_pcnext got=%h want=0502", PcNext); end
  endtask

  task automatic test_wrap();
    do_reset();
    PC = 16'hFFFE;
    step();
    MemDone = 1; MemData = 16'h7777;
    step();
    MemDone = 0;
    @(negedge clk);
    checks++; if (PcNext !== 16'h0000) begin errors++; $display("FAIL wrap_pcnext got=%h want=0000", PcNext); end
    checks++; if (Instr !== 16'h7777) begin errors++; $display("FAIL wrap_instr got=%h want=7777", Instr); end
  endtask

  task automatic test_halt();
    do_reset();
    PC = 16'h0600;
    step();
    HaltIn = 1;
    @(negedge clk);
    checks++; if (PcStall !== 1'b1) begin errors++; $display("FAIL halt_pulse_pcstall got=%b want=1", PcStall); end
    step();
    HaltIn = 0;
    for (int k = 0; k < 5; k++) begin
      MemDone = (k == 1); MemData = 16'h9999; Flush = (k == 3);
      @(negedge clk);
      checks++; if (MemRd !== 1'b0) begin errors++; $display("FAIL halt_memrd[%0d] got=%b want=0", k, MemRd); end
      checks++; if (PcStall !== 1'b1) begin errors++; $display("FAIL halt_pcstall[%0d] got=%b want=1", k, PcStall); end
      checks++; if (IfValid !== 1'b0) begin errors++; $display("FAIL halt_ifvalid[%0d] got=%b want=0", k, IfValid); end
      checks++; if (Instr !== 16'h0800) begin errors++; $display("FAIL halt_instr[%0d] got=%h want=0800", k, Instr); end
      step();
    end
    MemDone = 0; Flush = 0;
    do_reset();
    PC = 16'h0700;
    @(negedge clk);
    checks++; if (MemRd !== 1'b1) begin errors++; $display("FAIL halt_rst_memrd got=%b want=1", MemRd); end
    checks++; if (MemAddr !== 16'h0700) begin errors++; $display("FAIL halt_rst_addr got=%h want=0700", MemAddr); end
  endtask

  // Transaction-level reference: one outstanding read, a drop-next-return flag, a decode hold, halt.
  bit          m_halted, m_inflight, m_drop, m_hold, m_valid;
  logic [15:0] m_addr, m_instr, m_pcnext;

  task automatic model_reset();
    m_halted = 0; m_inflight = 0; m_drop = 0; m_hold = 0; m_valid = 0;
    m_addr = 0; m_instr = 16'h0800; m_pcnext = 0;
  endtask

  task automatic model_edge(input logic [15:0] pc, input logic [15:0] data, input bit done,
                            input bit fl, input bit st, input bit ht);
    bit issuing;
    issuing = !m_halted && !m_inflight && !m_hold;
    if (ht) begin
      m_halted = 1; m_valid = 0; m_inflight = 0; m_hold = 0;
    end else if (m_halted) begin
    end else if (fl) begin
      m_valid = 0; m_instr = 16'h0800; m_hold = 0;
      if (m_inflight) begin
        if (done) begin m_inflight = 0; m_drop = 0; end
        else m_drop = 1;
      end
    end else if (issuing) begin
      m_addr = pc; m_inflight = 1;
      if (!st) m_valid = 0;
    end else if (m_inflight) begin
      if (done && m_drop) begin
        m_inflight = 0; m_drop = 0;
        if (!st) m_valid = 0;
      end else if (done) begin
        m_inflight = 0;
        m_instr = data;
        m_pcnext = 16'((32'(m_addr) + 2) % 65536);
        m_valid = 1;
        m_hold = st;
      end else if (!st) begin
        m_valid = 0;
      end
    end else if (m_hold && !st) begin
      m_hold = 0; m_valid = 0;
    end
  endtask

  task automatic test_random();
    bit          e_rd, e_stall, issuing;
    logic [15:0] e_addr;
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 79) == 0);
      PC      = 16'($urandom_range(0, 32767) * 2);
      MemData = 16'($urandom);
      MemDone = ($urandom_range(0, 9) < 4);
      Flush   = ($urandom_range(0, 9) == 0);
      IdStall = ($urandom_range(0, 9) < 3);
      HaltIn  = ($urandom_range(0, 149) == 0);
      if (rst) model_reset();
      issuing = !m_halted && !m_inflight && !m_hold;
      e_rd    = issuing;
      e_addr  = issuing ? PC : m_addr;
      e_stall = !((Flush && !HaltIn && !m_halted) ||
                  (m_inflight && MemDone && !Flush && !HaltIn && !m_drop));
      @(negedge clk);
      checks++; if (MemRd !== e_rd) begin errors++; $display("FAIL rand_memrd[%0d] got=%b want=%b", i, MemRd, e_rd); end
      checks++; if (MemAddr !== e_addr) begin errors++; $display("FAIL rand_addr[%0d] got=%h want=%h", i, MemAddr, e_addr); end
      checks++; if (PcStall !== e_stall) begin errors++; $display("FAIL rand_pcstall[%0d] got=%b want=%b", i, PcStall, e_stall); end
      checks++; if (Instr !== m_instr) begin errors++; $display("FAIL rand_instr[%0d] got=%h want=%h", i, Instr, m_instr); end
      checks++; if (PcNext !== m_pcnext) begin errors++; $display("FAIL rand_pcnext[%0d] got=%h want=%h", i, PcNext, m_pcnext); end
      checks++; if (IfValid !== m_valid) begin errors++; $display("FAIL rand_ifvalid[%0d] got=%b want=%b", i, IfValid, m_valid); end
      @(posedge clk);
      if (!rst) model_edge(PC, MemData, MemDone, Flush, IdStall, HaltIn);
      #1;
    end
    rst = 0; MemDone = 0; Flush = 0; IdStall = 0; HaltIn = 0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold();
    test_flush_wait();
    test_flush_done();
    test_wrap();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
